// File: rtl/hgw_reg2apb_if.sv
// rtl/hgw_reg2apb_if.sv - request/response and APB3 bus bundle for hgw_reg2apb
interface hgw_reg2apb_if #(
  parameter int BW = 16
);
  // request channel
  logic          i_req_vld;
  logic          o_req_rdy;
  logic          i_req_write;
  logic [BW-1:0] i_req_addr;
  logic [31:0]   i_req_wdata;
  // response channel
  logic          o_rsp_vld;
  logic          i_rsp_rdy;
  logic [31:0]   o_rsp_rdata;
  logic          o_rsp_err;
  logic          o_rsp_timeout;
  // APB3 initiator side
  logic [BW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  // bridge view: accepts requests, returns responses, drives APB
  modport master (
    input  i_req_vld, i_req_write, i_req_addr, i_req_wdata, i_rsp_rdy,
    input  prdata, pready, pslverr,
    output o_req_rdy, o_rsp_vld, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    output paddr, psel, penable, pwrite, pwdata
  );

  // environment view: requester plus APB completer
  modport slave (
    output i_req_vld, i_req_write, i_req_addr, i_req_wdata, i_rsp_rdy,
    output prdata, pready, pslverr,
    input  o_req_rdy, o_rsp_vld, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    input  paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/hgw_reg2apb.sv
// rtl/hgw_reg2apb.sv - APB3 initiator bridge for single-outstanding register requests
module hgw_reg2apb #(
  parameter int BW      = 16,
  parameter int TIMEOUT = 256
) (
  input  logic          i_clk,
  input  logic          i_rst,
  hgw_reg2apb_if.master bus
);

  // Wait counter only has to reach TIMEOUT-1; keep at least one bit so the
  // declaration stays legal when the timeout is disabled.
  localparam int CW_RAW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam bit TO_EN  = (TIMEOUT > 0);
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // Ready is a pure decode of IDLE, forced low while reset is held.
  assign bus.o_req_rdy = (state == S_IDLE) && !i_rst;

  // Transfer sequencer: APB outputs and response fields are all registered here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= S_IDLE;
      wait_cnt          <= '0;
      bus.paddr         <= '0;
      bus.psel          <= 1'b0;
      bus.penable       <= 1'b0;
      bus.pwrite        <= 1'b0;
      bus.pwdata        <= '0;
      bus.o_rsp_vld     <= 1'b0;
      bus.o_rsp_rdata   <= '0;
      bus.o_rsp_err     <= 1'b0;
      bus.o_rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Request fields go straight into the APB registers so SETUP
          // already presents them; wdata is taken even for reads.
          if (bus.i_req_vld) begin
            bus.paddr  <= bus.i_req_addr;
            bus.pwrite <= bus.i_req_write;
            bus.pwdata <= bus.i_req_wdata;
            bus.psel   <= 1'b1;
            wait_cnt   <= '0;
            state      <= S_SETUP;
          end
        end

        S_SETUP: begin
          bus.penable <= 1'b1;
          state       <= S_ACCESS;
        end

        S_ACCESS: begin
          // pready has priority over the timeout when both land together.
          if (bus.pready) begin
            bus.psel          <= 1'b0;
            bus.penable       <= 1'b0;
            bus.o_rsp_vld     <= 1'b1;
            bus.o_rsp_err     <= bus.pslverr;
            bus.o_rsp_rdata   <= bus.pwrite ? 32'd0 : bus.prdata;
            bus.o_rsp_timeout <= 1'b0;
            state             <= S_RESP;
          end else if (TO_EN && (wait_cnt == WAIT_LAST)) begin
            bus.psel          <= 1'b0;
            bus.penable       <= 1'b0;
            bus.o_rsp_vld     <= 1'b1;
            bus.o_rsp_err     <= 1'b1;
            bus.o_rsp_rdata   <= 32'd0;
            bus.o_rsp_timeout <= 1'b1;
            state             <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_RESP: begin
          // Response fields hold until the consumer takes them.
          if (bus.i_rsp_rdy) begin
            bus.o_rsp_vld <= 1'b0;
            state         <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hgw_reg2apb.sv
// tb/tb_hgw_reg2apb.sv - self-checking bench for hgw_reg2apb
module tb_hgw_reg2apb;

  localparam int BW   = 16;
  localparam int TO_P = 4;

  logic i_clk;
  logic i_rst;

  hgw_reg2apb_if #(.BW(BW)) bus ();

  hgw_reg2apb #(.BW(BW), .TIMEOUT(TO_P)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.master)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Expected visible state for one clock cycle.
  typedef struct {
    bit          rdy;
    bit          psel;
    bit          pen;
    bit          vld;
    logic [15:0] addr;
    bit          wr;
    logic [31:0] wd;
    logic [31:0] rdata;
    bit          err;
    bit          tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int n_pass  = 0;
  int n_total = 0;

  int          psel_cnt;
  int          pen_cnt;
  logic [31:0] last_rdata;
  logic        last_err;
  logic        last_tmo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input bit rdy, input bit ps, input bit pe, input bit vld,
                      input logic [15:0] a, input bit w, input logic [31:0] wd,
                      input logic [31:0] rd, input bit er, input bit to);
    exp_t e;
    e.rdy = rdy; e.psel = ps; e.pen = pe; e.vld = vld;
    e.addr = a; e.wr = w; e.wd = wd; e.rdata = rd; e.err = er; e.tmo = to;
    exp_q.push_back(e);
  endtask

  // Compare process: one expected record per cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (bus.psel) psel_cnt++;
        if (bus.penable) pen_cnt++;
        if (bus.o_rsp_vld) begin
          last_rdata = bus.o_rsp_rdata;
          last_err   = bus.o_rsp_err;
          last_tmo   = bus.o_rsp_timeout;
        end
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("req_rdy", bus.o_req_rdy, cur.rdy);
          chk("psel", bus.psel, cur.psel);
          chk("penable", bus.penable, cur.pen);
          chk("rsp_vld", bus.o_rsp_vld, cur.vld);
          if (cur.psel) begin
            chk("paddr", bus.paddr, cur.addr);
            chk("pwrite", bus.pwrite, cur.wr);
            chk("pwdata", bus.pwdata, cur.wd);
          end
          if (cur.vld) begin
            chk("rsp_rdata", bus.o_rsp_rdata, cur.rdata);
            chk("rsp_err", bus.o_rsp_err, cur.err);
            chk("rsp_timeout", bus.o_rsp_timeout, cur.tmo);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      push(1, 0, 0, 0, '0, 0, '0, '0, 0, 0);
      @(posedge i_clk); #1;
    end
  endtask

  // One full transfer. waits = ACCESS cycles with pready low before the slave
  // answers; waits >= TO_P means the slave never answers.
  task automatic xfer(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd, input bit serr,
                      input int rsp_delay, input bit hold);
    bit          tmo;
    int          n_acc;
    logic [31:0] e_rd;
    bit          e_err;
    tmo   = (waits >= TO_P);
    n_acc = tmo ? TO_P : waits + 1;
    e_rd  = (tmo || wr) ? 32'd0 : rd;
    e_err = tmo || serr;
    push(1, 0, 0, 0, addr, wr, wd, e_rd, e_err, tmo);
    push(0, 1, 0, 0, addr, wr, wd, e_rd, e_err, tmo);
    for (int k = 0; k < n_acc; k++) push(0, 1, 1, 0, addr, wr, wd, e_rd, e_err, tmo);
    for (int k = 0; k <= rsp_delay; k++) push(0, 0, 0, 1, addr, wr, wd, e_rd, e_err, tmo);

    // accept cycle; slave-side inputs carry junk that must be ignored
    bus.i_req_vld   = 1'b1;
    bus.i_req_write = wr;
    bus.i_req_addr  = addr;
    bus.i_req_wdata = wd;
    bus.pready      = 1'b1;
    bus.pslverr     = 1'b1;
    bus.prdata      = 32'hBAD0_0001;
    bus.i_rsp_rdy   = 1'b1;
    @(posedge i_clk); #1;
    // SETUP
    if (hold) begin
      bus.i_req_write = ~wr;
      bus.i_req_addr  = ~addr;
      bus.i_req_wdata = ~wd;
    end else begin
      bus.i_req_vld = 1'b0;
    end
    @(posedge i_clk); #1;
    // ACCESS
    for (int k = 0; k < n_acc; k++) begin
      bus.pready  = (k >= waits);
      bus.pslverr = (k >= waits) ? serr : 1'b1;
      bus.prdata  = (k >= waits) ? rd : 32'hFFFF_FFFF;
      @(posedge i_clk); #1;
    end
    // RESP
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'hBAD0_0002;
    for (int k = 0; k <= rsp_delay; k++) begin
      bus.i_rsp_rdy = (k == rsp_delay);
      @(posedge i_clk); #1;
    end
    bus.i_rsp_rdy = 1'b0;
  endtask

  task automatic clr_obs();
    psel_cnt   = 0;
    pen_cnt    = 0;
    last_rdata = 32'hXXXX_XXXX;
    last_err   = 1'bx;
    last_tmo   = 1'bx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    i_rst           = 1'b0;
    bus.i_req_vld   = 1'b0;
    bus.i_req_write = 1'b0;
    bus.i_req_addr  = '0;
    bus.i_req_wdata = '0;
    bus.i_rsp_rdy   = 1'b0;
    bus.prdata      = '0;
    bus.pready      = 1'b0;
    bus.pslverr     = 1'b0;
    clr_obs();
    #1 i_rst = 1'b1;
    #2;
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_rsp_vld", bus.o_rsp_vld, 0);
    chk("rst_req_rdy", bus.o_req_rdy, 0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    chk("post_rst_req_rdy", bus.o_req_rdy, 1);
    @(posedge i_clk); #1;
    idle(2);

    // zero-wait write
    clr_obs();
    xfer(1, 16'h0010, 32'hA5A5_0001, 0, 32'h0, 0, 0, 0);
    chk("wr0_psel_cycles", psel_cnt, 2);
    chk("wr0_pen_cycles", pen_cnt, 1);
    chk("wr0_rdata", last_rdata, 32'h0);
    chk("wr0_err", last_err, 0);
    idle(1);

    // read with 3 wait states; last wait lands on the timeout count
    clr_obs();
    xfer(0, 16'h0024, 32'h5555_AAAA, 3, 32'hDEAD_BEEF, 0, 0, 0);
    chk("rd3_psel_cycles", psel_cnt, 5);
    chk("rd3_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("rd3_err", last_err, 0);
    chk("rd3_tmo", last_tmo, 0);
    idle(1);

    // slave error on read
    clr_obs();
    xfer(0, 16'h0030, 32'h0, 1, 32'h0000_1234, 1, 0, 0);
    chk("serr_rdata", last_rdata, 32'h0000_1234);
    chk("serr_err", last_err, 1);
    chk("serr_tmo", last_tmo, 0);
    idle(1);

    // timeout
    clr_obs();
    xfer(0, 16'h0040, 32'h0, 10, 32'h7777_7777, 0, 0, 0);
    chk("to_pen_cycles", pen_cnt, 4);
    chk("to_rdata", last_rdata, 32'h0);
    chk("to_err", last_err, 1);
    chk("to_tmo", last_tmo, 1);
    idle(1);

    // response backpressure with request held high, then back-to-back read
    xfer(1, 16'h0050, 32'h0BAD_F00D, 0, 32'h0, 0, 5, 1);
    clr_obs();
    xfer(0, 16'h0060, 32'h0, 2, 32'hCAFE_0001, 0, 0, 0);
    chk("b2b_rdata", last_rdata, 32'hCAFE_0001);
    chk("b2b_psel_cycles", psel_cnt, 4);
    idle(1);

    // async reset in the middle of ACCESS
    bus.i_req_vld   = 1'b1;
    bus.i_req_write = 1'b0;
    bus.i_req_addr  = 16'h0080;
    bus.pready      = 1'b0;
    @(posedge i_clk); #1;
    bus.i_req_vld = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("mid_psel", bus.psel, 1);
    chk("mid_penable", bus.penable, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_psel", bus.psel, 0);
    chk("arst_penable", bus.penable, 0);
    chk("arst_rsp_vld", bus.o_rsp_vld, 0);
    chk("arst_req_rdy", bus.o_req_rdy, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    chk("arst_rel_req_rdy", bus.o_req_rdy, 1);
    @(posedge i_clk); #1;
    idle(3);

    // normal transfers after reset, including a write with slave error
    clr_obs();
    xfer(1, 16'h0070, 32'h1357_9BDF, 1, 32'hFFFF_0000, 1, 1, 0);
    chk("wrerr_rdata", last_rdata, 32'h0);
    chk("wrerr_err", last_err, 1);
    chk("wrerr_tmo", last_tmo, 0);
    clr_obs();
    xfer(0, 16'hFFFC, 32'h0, 0, 32'h8000_0001, 0, 0, 0);
    chk("rd0_rdata", last_rdata, 32'h8000_0001);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
